// File: rtl/core_decode_queue.sv
// Decode queue: DEPTH-entry fetch FIFO feeding a registered micro-op stage; latency 2 (1 with CORE_DECODE_BYPASS_EN).
// Backpressure: IN_READY drops while the FIFO is full; OUT_READY low holds the decoded stage stable.
module core_decode_queue #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int UOP_W = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FLUSH,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [31:0]                IN_INST,
    input  logic [PC_W-1:0]            IN_PC,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [PC_W-1:0]            OUT_PC,
    output logic [UOP_W-1:0]           OUT_UOP,
    output logic [XLEN-1:0]            OUT_IMM,
    output logic [4:0]                 OUT_RD,
    output logic [4:0]                 OUT_RS1,
    output logic [4:0]                 OUT_RS2,
    output logic                       OUT_RDVALID,
    output logic                       OUT_FRDVALID,
    output logic                       OUT_ILLEGAL,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic [XLEN-1:0]  imm;
        logic             rdvalid;
        logic             frdvalid;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int unsigned code;
        logic [31:0] imm32;
        dec_t        d;
        opc  = inst[6:0];
        f3   = inst[14:12];
        f7   = inst[31:25];
        code = 0;
        case (opc)
            7'b0010011: begin
                case (f3)
                    3'b000:  code = 1;
                    3'b010:  code = 2;
                    3'b011:  code = 3;
                    3'b100:  code = 4;
                    3'b110:  code = 5;
                    3'b111:  code = 6;
                    3'b001:  code = 7;
                    default: code = (f7 == 7'b0000000) ? 8 : (f7 == 7'b0100000) ? 9 : 0;
                endcase
            end
            7'b0110011: begin
                case (f3)
                    3'b000:  code = (f7 == 7'b0000000) ? 10 : (f7 == 7'b0100000) ? 11 : 0;
                    3'b001:  code = 12;
                    3'b010:  code = 13;
                    3'b011:  code = 14;
                    3'b100:  code = 15;
                    3'b101:  code = (f7 == 7'b0000000) ? 16 : (f7 == 7'b0100000) ? 17 : 0;
                    3'b110:  code = 18;
                    default: code = 19;
                endcase
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  code = 20;
                    3'b001:  code = 21;
                    3'b100:  code = 22;
                    3'b101:  code = 23;
                    3'b110:  code = 24;
                    3'b111:  code = 25;
                    default: code = 0;
                endcase
            end
            7'b0000011: begin
                case (f3)
                    3'b000:  code = 26;
                    3'b001:  code = 27;
                    3'b010:  code = 28;
                    3'b100:  code = 29;
                    3'b101:  code = 30;
                    default: code = 0;
                endcase
            end
            7'b0100011: begin
                case (f3)
                    3'b000:  code = 31;
                    3'b001:  code = 32;
                    3'b010:  code = 33;
                    default: code = 0;
                endcase
            end
            7'b1100111: code = (f3 == 3'b000) ? 34 : 0;
            7'b1101111: code = 35;
            7'b0010111: code = 36;
            7'b0110111: code = 37;
            7'b0000111: code = (f3 == 3'b010) ? 38 : 0;
            7'b0100111: code = (f3 == 3'b010) ? 39 : 0;
            7'b1010011: begin
                // OP-FP: func7 selects the operation, func3 is rounding mode except where noted
                case (f7)
                    7'b0000000: code = 40;
                    7'b0000100: code = 41;
                    7'b0001000: code = 42;
                    7'b0001100: code = 43;
                    7'b1010000: begin
                        case (f3)
                            3'b010:  code = 44;
                            3'b001:  code = 45;
                            3'b000:  code = 46;
                            default: code = 0;
                        endcase
                    end
                    7'b0010000: code = (f3 == 3'b010) ? 47 : 0;
                    7'b1111000: code = (f3 == 3'b000) ? 48 : 0;
                    7'b1101000: code = 49;
                    7'b1100000: code = 50;
                    7'b0101100: code = 51;
                    default:    code = 0;
                endcase
            end
            7'b0001011: code = 52;
            7'b0000001: code = (f3 == 3'b000) ? 53 : (f3 == 3'b001) ? 54 : 0;
            default:    code = 0;
        endcase

        if (code inside {[1:9], [26:30], 34, 38})
            imm32 = {{20{inst[31]}}, inst[31:20]};
        else if (code inside {[31:33], 39})
            imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        else if (code inside {[20:25]})
            imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        else if (code inside {36, 37})
            imm32 = {inst[31:12], 12'b0};
        else if (code == 35)
            imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        else
            imm32 = 32'b0;

        d.uop      = UOP_W'(code);
        d.imm      = XLEN'($signed(imm32));
        d.rdvalid  = !(code == 0 || code inside {[20:25], [31:33], 39});
        d.frdvalid = code inside {38, 40, 41, 42, 43, 47, 48, 49, 51};
        return d;
    endfunction

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             stage_free;
    logic             bypass;
    logic             push;
    logic             pop;
    entry_t           load_ent;
    dec_t             dec;

    assign COUNT      = count_q;
    assign IN_READY   = (count_q != CNT_W'(DEPTH));
    assign stage_free = !OUT_VALID || OUT_READY;

`ifdef CORE_DECODE_BYPASS_EN
    assign bypass = IN_VALID && !FLUSH && stage_free && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push     = IN_VALID && IN_READY && !FLUSH && !bypass;
    assign pop      = stage_free && (count_q != '0) && !FLUSH;
    assign load_ent = bypass ? {IN_PC, IN_INST} : mem[rd_ptr];
    assign dec      = decode(load_ent.inst);

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {IN_PC, IN_INST};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID    <= 1'b0;
            OUT_PC       <= '0;
            OUT_UOP      <= '0;
            OUT_IMM      <= '0;
            OUT_RD       <= '0;
            OUT_RS1      <= '0;
            OUT_RS2      <= '0;
            OUT_RDVALID  <= 1'b0;
            OUT_FRDVALID <= 1'b0;
            OUT_ILLEGAL  <= 1'b0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (pop || bypass) begin
            OUT_VALID    <= 1'b1;
            OUT_PC       <= load_ent.pc;
            OUT_UOP      <= dec.uop;
            OUT_IMM      <= dec.imm;
            OUT_RD       <= load_ent.inst[11:7];
            OUT_RS1      <= load_ent.inst[19:15];
            OUT_RS2      <= load_ent.inst[24:20];
            OUT_RDVALID  <= dec.rdvalid;
            OUT_FRDVALID <= dec.frdvalid;
            OUT_ILLEGAL  <= (dec.uop == '0);
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_decode_queue.sv
// Bench for core_decode_queue: directed scenarios plus randomized traffic against a table-driven queue model.
module tb_core_decode_queue;

    localparam int DEPTH = 4;
    localparam int F_N = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;
`ifdef CORE_DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [31:0] IN_INST, IN_PC, OUT_PC, OUT_IMM;
    logic [5:0]  OUT_UOP;
    logic [4:0]  OUT_RD, OUT_RS1, OUT_RS2;
    logic        OUT_RDVALID, OUT_FRDVALID, OUT_ILLEGAL;
    logic [2:0]  COUNT;

    core_decode_queue #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH), .UOP_W(6)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC), .OUT_UOP(OUT_UOP),
        .OUT_IMM(OUT_IMM), .OUT_RD(OUT_RD), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
        .OUT_RDVALID(OUT_RDVALID), .OUT_FRDVALID(OUT_FRDVALID), .OUT_ILLEGAL(OUT_ILLEGAL),
        .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit [6:0] opc;
        bit       f3c;
        bit [2:0] f3;
        bit       f7c;
        bit [6:0] f7;
        int       uop;
        int       fmt;
        bit       frd;
    } tmpl_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        int          uop;
        logic [31:0] imm;
        bit          rdv;
        bit          frdv;
    } exp_t;

    tmpl_t tbl[$];
    exp_t  mq[$];
    exp_t  mo;
    bit    mo_v;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function void add_t(bit [6:0] opc, bit f3c, bit [2:0] f3, bit f7c, bit [6:0] f7,
                        int uop, int fmt, bit frd);
        tbl.push_back('{opc, f3c, f3, f7c, f7, uop, fmt, frd});
    endfunction

    task automatic build_tbl();
        add_t(7'b0010011, 1, 3'b000, 0, 7'h00,  1, F_I, 0);
        add_t(7'b0010011, 1, 3'b010, 0, 7'h00,  2, F_I, 0);
        add_t(7'b0010011, 1, 3'b011, 0, 7'h00,  3, F_I, 0);
        add_t(7'b0010011, 1, 3'b100, 0, 7'h00,  4, F_I, 0);
        add_t(7'b0010011, 1, 3'b110, 0, 7'h00,  5, F_I, 0);
        add_t(7'b0010011, 1, 3'b111, 0, 7'h00,  6, F_I, 0);
        add_t(7'b0010011, 1, 3'b001, 0, 7'h00,  7, F_I, 0);
        add_t(7'b0010011, 1, 3'b101, 1, 7'b0000000, 8, F_I, 0);
        add_t(7'b0010011, 1, 3'b101, 1, 7'b0100000, 9, F_I, 0);
        add_t(7'b0110011, 1, 3'b000, 1, 7'b0000000, 10, F_N, 0);
        add_t(7'b0110011, 1, 3'b000, 1, 7'b0100000, 11, F_N, 0);
        add_t(7'b0110011, 1, 3'b001, 0, 7'h00, 12, F_N, 0);
        add_t(7'b0110011, 1, 3'b010, 0, 7'h00, 13, F_N, 0);
        add_t(7'b0110011, 1, 3'b011, 0, 7'h00, 14, F_N, 0);
        add_t(7'b0110011, 1, 3'b100, 0, 7'h00, 15, F_N, 0);
        add_t(7'b0110011, 1, 3'b101, 1, 7'b0000000, 16, F_N, 0);
        add_t(7'b0110011, 1, 3'b101, 1, 7'b0100000, 17, F_N, 0);
        add_t(7'b0110011, 1, 3'b110, 0, 7'h00, 18, F_N, 0);
        add_t(7'b0110011, 1, 3'b111, 0, 7'h00, 19, F_N, 0);
        add_t(7'b1100011, 1, 3'b000, 0, 7'h00, 20, F_B, 0);
        add_t(7'b1100011, 1, 3'b001, 0, 7'h00, 21, F_B, 0);
        add_t(7'b1100011, 1, 3'b100, 0, 7'h00, 22, F_B, 0);
        add_t(7'b1100011, 1, 3'b101, 0, 7'h00, 23, F_B, 0);
        add_t(7'b1100011, 1, 3'b110, 0, 7'h00, 24, F_B, 0);
        add_t(7'b1100011, 1, 3'b111, 0, 7'h00, 25, F_B, 0);
        add_t(7'b0000011, 1, 3'b000, 0, 7'h00, 26, F_I, 0);
        add_t(7'b0000011, 1, 3'b001, 0, 7'h00, 27, F_I, 0);
        add_t(7'b0000011, 1, 3'b010, 0, 7'h00, 28, F_I, 0);
        add_t(7'b0000011, 1, 3'b100, 0, 7'h00, 29, F_I, 0);
        add_t(7'b0000011, 1, 3'b101, 0, 7'h00, 30, F_I, 0);
        add_t(7'b0100011, 1, 3'b000, 0, 7'h00, 31, F_S, 0);
        add_t(7'b0100011, 1, 3'b001, 0, 7'h00, 32, F_S, 0);
        add_t(7'b0100011, 1, 3'b010, 0, 7'h00, 33, F_S, 0);
        add_t(7'b1100111, 1, 3'b000, 0, 7'h00, 34, F_I, 0);
        add_t(7'b1101111, 0, 3'b000, 0, 7'h00, 35, F_J, 0);
        add_t(7'b0010111, 0, 3'b000, 0, 7'h00, 36, F_U, 0);
        add_t(7'b0110111, 0, 3'b000, 0, 7'h00, 37, F_U, 0);
        add_t(7'b0000111, 1, 3'b010, 0, 7'h00, 38, F_I, 1);
        add_t(7'b0100111, 1, 3'b010, 0, 7'h00, 39, F_S, 0);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b0000000, 40, F_N, 1);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b0000100, 41, F_N, 1);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b0001000, 42, F_N, 1);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b0001100, 43, F_N, 1);
        add_t(7'b1010011, 1, 3'b010, 1, 7'b1010000, 44, F_N, 0);
        add_t(7'b1010011, 1, 3'b001, 1, 7'b1010000, 45, F_N, 0);
        add_t(7'b1010011, 1, 3'b000, 1, 7'b1010000, 46, F_N, 0);
        add_t(7'b1010011, 1, 3'b010, 1, 7'b0010000, 47, F_N, 1);
        add_t(7'b1010011, 1, 3'b000, 1, 7'b1111000, 48, F_N, 1);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b1101000, 49, F_N, 1);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b1100000, 50, F_N, 0);
        add_t(7'b1010011, 0, 3'b000, 1, 7'b0101100, 51, F_N, 1);
        add_t(7'b0001011, 0, 3'b000, 0, 7'h00, 52, F_N, 0);
        add_t(7'b0000001, 1, 3'b000, 0, 7'h00, 53, F_N, 0);
        add_t(7'b0000001, 1, 3'b001, 0, 7'h00, 54, F_N, 0);
        // near-miss encodings that must decode as illegal
        add_t(7'b1111111, 0, 3'b000, 0, 7'h00, 0, F_N, 0);
        add_t(7'b0010011, 1, 3'b101, 1, 7'b0000001, 0, F_N, 0);
        add_t(7'b0110011, 1, 3'b000, 1, 7'b0000001, 0, F_N, 0);
        add_t(7'b0110011, 1, 3'b101, 1, 7'b1100000, 0, F_N, 0);
        add_t(7'b0000011, 1, 3'b011, 0, 7'h00, 0, F_N, 0);
        add_t(7'b1100011, 1, 3'b010, 0, 7'h00, 0, F_N, 0);
        add_t(7'b0100111, 1, 3'b000, 0, 7'h00, 0, F_N, 0);
    endtask

    function automatic exp_t classify(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   fmt;
        bit   hit;
        e.inst = inst; e.pc = pc; e.uop = 0; e.frdv = 0;
        fmt = F_N; hit = 0;
        foreach (tbl[k]) begin
            if (!hit && inst[6:0] == tbl[k].opc && (!tbl[k].f3c || inst[14:12] == tbl[k].f3)
                && (!tbl[k].f7c || inst[31:25] == tbl[k].f7)) begin
                hit = 1; e.uop = tbl[k].uop; fmt = tbl[k].fmt; e.frdv = tbl[k].frd;
            end
        end
        case (fmt)
            F_I:     e.imm = {{20{inst[31]}}, inst[31:20]};
            F_S:     e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            F_B:     e.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            F_U:     e.imm = {inst[31:12], 12'b0};
            F_J:     e.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: e.imm = 32'b0;
        endcase
        e.rdv = (e.uop != 0) && (fmt != F_S) && (fmt != F_B);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        tmpl_t       t;
        logic [31:0] w;
        t = tbl[$urandom_range(0, tbl.size() - 1)];
        w = $urandom;
        w[6:0] = t.opc;
        if (t.f3c) w[14:12] = t.f3;
        if (t.f7c) w[31:25] = t.f7;
        return w;
    endfunction

    task automatic compare_state();
        chk("count", COUNT, mq.size());
        chk("in_ready", IN_READY, mq.size() != DEPTH);
        chk("out_valid", OUT_VALID, mo_v);
        if (mo_v) begin
            chk("out_pc", OUT_PC, mo.pc);
            chk("out_uop", OUT_UOP, mo.uop);
            chk("out_imm", OUT_IMM, mo.imm);
            chk("out_rd", OUT_RD, mo.inst[11:7]);
            chk("out_rs1", OUT_RS1, mo.inst[19:15]);
            chk("out_rs2", OUT_RS2, mo.inst[24:20]);
            chk("out_rdvalid", OUT_RDVALID, mo.rdv);
            chk("out_frdvalid", OUT_FRDVALID, mo.frdv);
            chk("out_illegal", OUT_ILLEGAL, mo.uop == 0);
        end
    endtask

    // Whole-pipeline model: a queue for the FIFO plus one slot for the output stage.
    task automatic model_edge();
        bit   can_load, acc, byp;
        int   old;
        exp_t in_e;
        if (FLUSH) begin
            mq.delete();
            mo_v = 0;
        end else begin
            can_load = !mo_v || OUT_READY;
            old      = mq.size();
            acc      = IN_VALID && (old != DEPTH);
            in_e     = classify(IN_INST, IN_PC);
            byp      = BYP && acc && can_load && (old == 0);
            if (byp) begin
                mo = in_e; mo_v = 1;
            end else if (can_load && old > 0) begin
                mo = mq.pop_front(); mo_v = 1;
            end else if (OUT_READY) begin
                mo_v = 0;
            end
            if (acc && !byp) mq.push_back(in_e);
        end
    endtask

    task automatic tick();
        compare_state();
        model_edge();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int seen0, seen1;
        bit acc;
        build_tbl();
        RST = 1; FLUSH = 0; IN_VALID = 0; IN_INST = 0; IN_PC = 0; OUT_READY = 0;
        mo_v = 0;
        @(negedge CLK);
        chk("rst_count", COUNT, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_uop", OUT_UOP, 0);
        chk("rst_imm", OUT_IMM, 0);
        chk("rst_pc", OUT_PC, 0);
        chk("rst_illegal", OUT_ILLEGAL, 0);
        RST = 0;

        // addi x1,x0,5
        OUT_READY = 1; IN_VALID = 1; IN_INST = 32'h0050_0093; IN_PC = 32'h100;
        tick();
        IN_VALID = 0;
        chk("addi_first_cycle_valid", OUT_VALID, BYP);
        if (!BYP) tick();
        chk("addi_valid", OUT_VALID, 1);
        chk("addi_uop", OUT_UOP, 1);
        chk("addi_imm", OUT_IMM, 5);
        chk("addi_rd", OUT_RD, 1);
        chk("addi_rs1", OUT_RS1, 0);
        chk("addi_rdvalid", OUT_RDVALID, 1);
        chk("addi_pc", OUT_PC, 32'h100);
        repeat (2) tick();

        // beq x1,x2,-4
        IN_VALID = 1; IN_INST = 32'hFE20_8EE3; IN_PC = 32'h104;
        tick();
        IN_VALID = 0;
        if (!BYP) tick();
        chk("beq_uop", OUT_UOP, 20);
        chk("beq_imm", OUT_IMM, 32'hFFFF_FFFC);
        chk("beq_rs1", OUT_RS1, 1);
        chk("beq_rs2", OUT_RS2, 2);
        chk("beq_rdvalid", OUT_RDVALID, 0);
        repeat (2) tick();

        // fill under backpressure: five fit, the sixth waits
        OUT_READY = 0;
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1; IN_INST = rand_inst(); IN_PC = 32'h200 + 4 * i;
            if (i == 5) begin
                chk("full_count", COUNT, DEPTH);
                chk("full_in_ready", IN_READY, 0);
            end
            tick();
        end
        tick();
        OUT_READY = 1;
        for (int k = 0; k < 6; k++) begin
            chk("drain_valid", OUT_VALID, 1);
            chk("drain_order_pc", OUT_PC, 32'h200 + 4 * k);
            acc = IN_VALID && IN_READY;
            tick();
            if (acc) IN_VALID = 0;
        end
        chk("drain_done_valid", OUT_VALID, 0);
        chk("drain_done_count", COUNT, 0);

        // flush with a same-cycle push
        OUT_READY = 0;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1; IN_INST = rand_inst(); IN_PC = 32'h300 + 4 * i;
            tick();
        end
        FLUSH = 1; IN_VALID = 1; IN_INST = 32'h0050_0093; IN_PC = 32'h3F0;
        tick();
        FLUSH = 0; IN_VALID = 0;
        chk("flush_count", COUNT, 0);
        chk("flush_valid", OUT_VALID, 0);
        OUT_READY = 1;
        for (int k = 0; k < 4; k++) begin
            chk("flush_dropped", OUT_VALID, 0);
            tick();
        end

        // illegal word and exact-func7 SRAI
        IN_VALID = 1; IN_INST = 32'h0000_0000; IN_PC = 32'h400;
        tick();
        IN_INST = 32'h4000_D093; IN_PC = 32'h404;
        tick();
        IN_VALID = 0;
        seen0 = 0; seen1 = 0;
        for (int k = 0; k < 6; k++) begin
            if (OUT_VALID && OUT_PC == 32'h400) begin
                chk("zero_uop", OUT_UOP, 0);
                chk("zero_illegal", OUT_ILLEGAL, 1);
                chk("zero_rdvalid", OUT_RDVALID, 0);
                seen0++;
            end
            if (OUT_VALID && OUT_PC == 32'h404) begin
                chk("srai_uop", OUT_UOP, 9);
                seen1++;
            end
            tick();
        end
        chk("zero_seen", seen0, 1);
        chk("srai_seen", seen1, 1);

        // asynchronous reset mid-stream
        OUT_READY = 0;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1; IN_INST = rand_inst(); IN_PC = 32'h500 + 4 * i;
            tick();
        end
        IN_VALID = 0;
        chk("pre_rst_count", COUNT, 3);
        chk("pre_rst_valid", OUT_VALID, 1);
        #2 RST = 1;
        #1;
        chk("async_rst_count", COUNT, 0);
        chk("async_rst_valid", OUT_VALID, 0);
        chk("async_rst_uop", OUT_UOP, 0);
        chk("async_rst_pc", OUT_PC, 0);
        chk("async_rst_in_ready", IN_READY, 1);
        mq.delete(); mo_v = 0;
        @(negedge CLK);
        RST = 0;
        OUT_READY = 1; IN_VALID = 1; IN_INST = 32'h0050_0093; IN_PC = 32'h600;
        tick();
        IN_VALID = 0;
        seen0 = 0;
        for (int k = 0; k < 4; k++) begin
            if (OUT_VALID) begin
                chk("post_rst_uop", OUT_UOP, 1);
                chk("post_rst_pc", OUT_PC, 32'h600);
                chk("post_rst_imm", OUT_IMM, 5);
                seen0++;
            end
            tick();
        end
        chk("post_rst_seen", seen0, 1);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            FLUSH     = ($urandom_range(0, 49) == 0);
            IN_VALID  = ($urandom_range(0, 9) < 7);
            IN_INST   = rand_inst();
            IN_PC     = $urandom;
            OUT_READY = ($urandom_range(0, 3) != 0);
            tick();
        end
        FLUSH = 0; IN_VALID = 0; OUT_READY = 1;
        repeat (8) tick();
        chk("final_count", COUNT, 0);
        chk("final_valid", OUT_VALID, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
